// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, default latencies.
package md_pkg;

    // Ten operations need four bits of encoding
    localparam int unsigned OP_W             = 4;
    localparam int unsigned MULT_CYCLES_DEF  = 5;
    localparam int unsigned DIV_CYCLES_DEF   = 10;

    typedef enum logic [OP_W-1:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MTHI  = 4'd4,
        MD_MTLO  = 4'd5,
        MD_MADD  = 4'd6,
        MD_MADDU = 4'd7,
        MD_MSUB  = 4'd8,
        MD_MSUBU = 4'd9
    } md_op_e;

    // One-hot so the state register doubles as the busy bus
    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_MUL  = 3'b001,
        ST_DIV  = 3'b010,
        ST_MAC  = 3'b100
    } md_state_e;

    function automatic int unsigned cnt_width(input int unsigned mul_n, input int unsigned div_n);
        int unsigned m;
        m = (mul_n > div_n) ? mul_n : div_n;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage request / HI-LO result bundle between pipeline and md_unit.
interface md_unit_if #(
    parameter int unsigned WIDTH = 32
) ();
    import md_pkg::*;

    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [2:0]       busy;

    modport master (output start, op, a, b, input hi, lo, busy);
    modport slave  (input start, op, a, b, output hi, lo, busy);

endinterface

// File: rtl/md_counter.sv
// Loadable down-counter that models multi-cycle latency; zero flag is decoded from the count register.
module md_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit with cycle-exact busy for pipeline stall.
// Optional MADD/MADDU/MSUB/MSUBU support when MD_MADD_EN is defined.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam int unsigned DW    = 2 * WIDTH;

    md_state_e        state, state_nxt;
    md_op_e           op_in, op_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, hi_nxt, lo_nxt;
    logic             hi_we, lo_we, load_c, cnt_zero;
    logic [CNT_W-1:0] load_val;

    assign op_in = md_op_e'(bus.op);

    function automatic logic is_mul(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mac(input md_op_e op);
`ifdef MD_MADD_EN
        return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
        return (op == MD_MADD) && 1'b0;
`endif
    endfunction

    // Shared multiplier on latched operands, sign-extended or zero-extended to the full product width
    logic          mul_signed;
    logic [DW-1:0] a_ext, b_ext, prod;

    assign mul_signed = (op_q == MD_MULT) || (op_q == MD_MADD) || (op_q == MD_MSUB);
    assign a_ext      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign b_ext      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod       = a_ext * b_ext;

    // Sign-magnitude divide; the -2^(W-1)/-1 case falls out as quotient 0x80..0, remainder 0
    logic             div_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign div_signed = (op_q == MD_DIV);
    assign a_neg      = div_signed & a_q[WIDTH-1];
    assign b_neg      = div_signed & b_q[WIDTH-1];
    assign a_mag      = a_neg ? WIDTH'(-a_q) : a_q;
    assign b_mag      = b_neg ? WIDTH'(-b_q) : b_q;
    assign b_safe     = (b_mag == '0) ? WIDTH'(1) : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign quot       = (a_neg ^ b_neg) ? WIDTH'(-q_mag) : q_mag;
    assign rem        = a_neg ? WIDTH'(-r_mag) : r_mag;

`ifdef MD_MADD_EN
    logic          mac_sub;
    logic [DW-1:0] acc;

    assign mac_sub = (op_q == MD_MSUB) || (op_q == MD_MSUBU);
    assign acc     = mac_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`endif

    md_counter #(.W(CNT_W)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (load_c),
        .load_val (load_val),
        .dec      (state != ST_IDLE),
        .zero_c   (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_mul(op_in))      state_nxt = ST_MUL;
                    else if (is_div(op_in)) state_nxt = ST_DIV;
                    else if (is_mac(op_in)) state_nxt = ST_MAC;
                end
            end
            default: begin
                if (cnt_zero) state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        load_c   = 1'b0;
        load_val = CNT_W'(MULT_CYCLES - 1);
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_nxt   = hi_q;
        lo_nxt   = lo_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load_c = is_mul(op_in) || is_div(op_in) || is_mac(op_in);
                    if (is_div(op_in)) load_val = CNT_W'(DIV_CYCLES - 1);
                    if (op_in == MD_MTHI) begin
                        hi_we  = 1'b1;
                        hi_nxt = bus.a;
                    end
                    if (op_in == MD_MTLO) begin
                        lo_we  = 1'b1;
                        lo_nxt = bus.a;
                    end
                end
            end
            ST_MUL: begin
                if (cnt_zero) begin
                    hi_we            = 1'b1;
                    lo_we            = 1'b1;
                    {hi_nxt, lo_nxt} = prod;
                end
            end
            ST_DIV: begin
                // Divide by zero burns the latency but leaves HI/LO alone
                if (cnt_zero && (b_q != '0)) begin
                    hi_we  = 1'b1;
                    lo_we  = 1'b1;
                    hi_nxt = rem;
                    lo_nxt = quot;
                end
            end
`ifdef MD_MADD_EN
            ST_MAC: begin
                if (cnt_zero) begin
                    hi_we            = 1'b1;
                    lo_we            = 1'b1;
                    {hi_nxt, lo_nxt} = acc;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= MD_MULT;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (load_c) begin
                a_q  <= bus.a;
                b_q  <= bus.b;
                op_q <= op_in;
            end
            if (hi_we) hi_q <= hi_nxt;
            if (lo_we) lo_q <= lo_nxt;
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
`ifdef MD_MADD_EN
    assign bus.busy = state;
`else
    assign bus.busy = {1'b0, state[1:0]};
`endif

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with a cycle-level arithmetic model; exercises MD_MADD_EN ops when defined.
module tb_md_unit;
    import md_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(32)) bus ();

    md_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: architectural HI/LO, remaining busy cycles, and the result that lands when they run out
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic [2:0]  m_busy = '0;
    logic        p_we = 1'b0;
    int          m_rem = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic launch(input logic [63:0] r, input logic we, input int n, input logic [2:0] code);
        {p_hi, p_lo} = r;
        p_we   = we;
        m_rem  = n;
        m_busy = code;
    endtask

    task automatic model_edge();
        longint sa, sb, q, rm;
        longint unsigned ua, ub;
        sa = longint'($signed(bus.a));
        sb = longint'($signed(bus.b));
        ua = {32'b0, bus.a};
        ub = {32'b0, bus.b};
        if (reset) begin
            m_hi = '0; m_lo = '0; m_busy = '0; m_rem = 0; p_we = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                if (p_we) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
                m_busy = '0;
            end
        end else if (bus.start) begin
            case (bus.op)
                MD_MULT:  launch(64'(sa * sb), 1'b1, MC, 3'b001);
                MD_MULTU: launch(64'(ua * ub), 1'b1, MC, 3'b001);
                MD_DIV: begin
                    q  = (sb != 0) ? sa / sb : 0;
                    rm = (sb != 0) ? sa % sb : 0;
                    launch({32'(rm), 32'(q)}, sb != 0, DC, 3'b010);
                end
                MD_DIVU: begin
                    q  = (ub != 0) ? longint'(ua / ub) : 0;
                    rm = (ub != 0) ? longint'(ua % ub) : 0;
                    launch({32'(rm), 32'(q)}, ub != 0, DC, 3'b010);
                end
                MD_MTHI: m_hi = bus.a;
                MD_MTLO: m_lo = bus.a;
`ifdef MD_MADD_EN
                MD_MADD:  launch({m_hi, m_lo} + 64'(sa * sb), 1'b1, MC, 3'b100);
                MD_MADDU: launch({m_hi, m_lo} + 64'(ua * ub), 1'b1, MC, 3'b100);
                MD_MSUB:  launch({m_hi, m_lo} - 64'(sa * sb), 1'b1, MC, 3'b100);
                MD_MSUBU: launch({m_hi, m_lo} - 64'(ua * ub), 1'b1, MC, 3'b100);
`endif
                default: ;
            endcase
        end
    endtask

    // Advance one clock, update the model at the edge, then compare just after it
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("hi", bus.hi, m_hi);
        check("lo", bus.lo, m_lo);
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = s;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    task automatic wait_idle(input int exp_n);
        int n;
        n = 1;
        while (bus.busy != 3'b000 && n < 60) begin
            step();
            n++;
        end
        check("busy_len", 32'(n - 1), 32'(exp_n));
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_n, input logic [2:0] exp_code);
        drive(1'b1, op, a, b);
        step();
        drive(1'b0, op, '0, '0);
        check("busy_code", 32'(bus.busy), 32'(exp_code));
        wait_idle(exp_n);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'd0, '0, '0);
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);

        run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, MC, 3'b001);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);

        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, MC, 3'b001);
        check("multu_hi", bus.hi, 32'h0000_0002);
        check("multu_lo", bus.lo, 32'hFFFF_FFFA);

        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, DC, 3'b010);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);

        drive(1'b1, MD_MTHI, 32'h0000_1234, '0);
        step();
        drive(1'b0, 4'd0, '0, '0);
        check("mthi_hi", bus.hi, 32'h0000_1234);
        check("mthi_busy", 32'(bus.busy), 32'h0);

        run_op(MD_DIV, 32'd5, 32'd0, DC, 3'b010);
        check("div0_hi", bus.hi, 32'h0000_1234);
        check("div0_lo", bus.lo, 32'hFFFF_FFFD);

        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 3'b010);
        check("ovf_lo", bus.lo, 32'h8000_0000);
        check("ovf_hi", bus.hi, 32'h0);

        // Unknown opcode is dropped
        drive(1'b1, 4'hF, 32'hAAAA_AAAA, 32'd1);
        step();
        drive(1'b0, 4'd0, '0, '0);
        check("unk_busy", 32'(bus.busy), 32'h0);

        // MTHI during a multiply must not land, and the next op issues in the cycle busy drops
        drive(1'b1, MD_MULT, 32'd2, 32'd3);
        step();
        drive(1'b1, MD_MTHI, 32'h0000_0055, '0);
        step();
        drive(1'b0, 4'd0, '0, '0);
        wait_idle(MC - 1);
        check("ign_hi", bus.hi, 32'h0);
        check("ign_lo", bus.lo, 32'h0000_0006);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 3'b001);
        check("b2b_hi", bus.hi, 32'hFFFF_FFFE);
        check("b2b_lo", bus.lo, 32'h0000_0001);

        // Reset in the fourth busy cycle of a DIVU discards the result
        drive(1'b1, MD_DIVU, 32'd100, 32'd7);
        step();
        drive(1'b1, MD_MTLO, 32'h0000_DEAD, '0);
        step();
        drive(1'b0, 4'd0, '0, '0);
        step();
        step();
        check("divu_busy4", 32'(bus.busy), 32'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_hi", bus.hi, 32'h0);
        check("mid_rst_lo", bus.lo, 32'h0);
        step();

`ifdef MD_MADD_EN
        drive(1'b1, MD_MTLO, 32'd10, '0);
        step();
        run_op(MD_MADD, 32'd2, 32'd3, MC, 3'b100);
        check("madd_lo", bus.lo, 32'd16);
        check("madd_hi", bus.hi, 32'h0);
        run_op(MD_MSUB, 32'd1, 32'd20, MC, 3'b100);
        check("msub_lo", bus.lo, 32'hFFFF_FFFC);
        check("msub_hi", bus.hi, 32'hFFFF_FFFF);
`else
        drive(1'b1, MD_MADD, 32'd2, 32'd3);
        step();
        drive(1'b0, 4'd0, '0, '0);
        check("madd_off_busy", 32'(bus.busy), 32'h0);
        check("madd_off_lo", bus.lo, 32'h0);
`endif
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
